// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the SPARC datapath and the pipeline sequencer.
// Statistics counters appear only when HCU_STATS_EN is defined.
interface hazard_control_unit_if;
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic [4:0] ID_rd;
    logic       ID_i;
    logic       ID_store;
    logic       ID_B_instr;
    logic       ID_29_a;
    logic       ID_br_always;
    logic       ID_cond_true;
    logic [4:0] EX_RD;
    logic [4:0] MEM_RD;
    logic [4:0] WB_RD;
    logic       EX_RF_enable;
    logic       MEM_RF_enable;
    logic       WB_RF_enable;
    logic       EX_load_instr;
    logic       LE_PC;
    logic       LE_nPC;
    logic       LE_IF_ID;
    logic       S;
    logic       IF_ID_clr;
    logic [1:0] FWD_PA;
    logic [1:0] FWD_PB;
    logic [1:0] FWD_DI;
    logic [1:0] state;
`ifdef HCU_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] annul_cnt;
`endif

    // Datapath side: supplies decode/pipeline info, consumes enables and selects.
    modport master (
        output ID_rs1, ID_rs2, ID_rd, ID_i, ID_store, ID_B_instr, ID_29_a,
               ID_br_always, ID_cond_true, EX_RD, MEM_RD, WB_RD,
               EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr,
        input  LE_PC, LE_nPC, LE_IF_ID, S, IF_ID_clr, FWD_PA, FWD_PB, FWD_DI, state
`ifdef HCU_STATS_EN
        , input stall_cnt, annul_cnt
`endif
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_rd, ID_i, ID_store, ID_B_instr, ID_29_a,
               ID_br_always, ID_cond_true, EX_RD, MEM_RD, WB_RD,
               EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_load_instr,
        output LE_PC, LE_nPC, LE_IF_ID, S, IF_ID_clr, FWD_PA, FWD_PB, FWD_DI, state
`ifdef HCU_STATS_EN
        , output stall_cnt, annul_cnt
`endif
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer for the 5-stage SPARC datapath: startup drain, load-use stalls,
// delay-slot annul and ID-stage operand forwarding. Define HCU_STATS_EN for stall/annul counters.
module hazard_control_unit #(
    parameter int STARTUP_CYCLES    = 2,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 R,
    hazard_control_unit_if.slave hcu
);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'b00,
        ST_RUN     = 2'b01,
        ST_STALL   = 2'b10,
        ST_UNUSED  = 2'b11
    } state_t;

    localparam logic [7:0] STARTUP_INIT = 8'(STARTUP_CYCLES);
    localparam logic [7:0] STALL_INIT   = 8'(LOAD_STALL_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    logic       load_use;
    logic       annul;
    logic       ex_fwd_ok;
    logic       le_int;
    logic       s_int;
    logic       clr_int;

    // A load in EX has no data yet, so it stalls instead of forwarding.
    assign load_use = hcu.EX_load_instr && hcu.EX_RF_enable && (hcu.EX_RD != 5'd0) &&
                      ((hcu.EX_RD == hcu.ID_rs1) ||
                       ((hcu.EX_RD == hcu.ID_rs2) && !hcu.ID_i) ||
                       ((hcu.EX_RD == hcu.ID_rd) && hcu.ID_store));

    assign annul = hcu.ID_B_instr && hcu.ID_29_a && (!hcu.ID_cond_true || hcu.ID_br_always);

    assign ex_fwd_ok = hcu.EX_RF_enable && !hcu.EX_load_instr;

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state_reg <= ST_STARTUP;
            cnt_reg   <= STARTUP_INIT;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        le_int     = 1'b0;
        s_int      = 1'b1;
        clr_int    = 1'b0;
        case (state_reg)
            ST_STARTUP: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_use) begin
                    // The first bubble is this cycle; extra bubbles come from STALL.
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_next = ST_STALL;
                        cnt_next   = STALL_INIT;
                    end
                end else begin
                    le_int  = 1'b1;
                    s_int   = 1'b0;
                    clr_int = annul;
                end
            end
            ST_STALL: begin
                cnt_next = cnt_reg - 8'd1;
                if (cnt_reg <= 8'd1) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_STARTUP;
                cnt_next   = STARTUP_INIT;
            end
        endcase
    end

    assign hcu.LE_PC     = le_int;
    assign hcu.LE_nPC    = le_int;
    assign hcu.LE_IF_ID  = le_int;
    assign hcu.S         = s_int;
    assign hcu.IF_ID_clr = clr_int;
    assign hcu.state     = state_reg;

    // Operand order: 0 = rs1 -> PA, 1 = rs2 -> PB, 2 = rd -> DI. Youngest producer wins.
    logic [4:0] fwd_src [3];
    logic [1:0] fwd_sel [3];

    assign fwd_src[0] = hcu.ID_rs1;
    assign fwd_src[1] = hcu.ID_rs2;
    assign fwd_src[2] = hcu.ID_rd;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (fwd_src[gi] == 5'd0)                               ? 2'b00 :
                (ex_fwd_ok && (hcu.EX_RD == fwd_src[gi]))           ? 2'b01 :
                (hcu.MEM_RF_enable && (hcu.MEM_RD == fwd_src[gi]))  ? 2'b10 :
                (hcu.WB_RF_enable && (hcu.WB_RD == fwd_src[gi]))    ? 2'b11 :
                                                                      2'b00;
        end
    endgenerate

    assign hcu.FWD_PA = fwd_sel[0];
    assign hcu.FWD_PB = fwd_sel[1];
    assign hcu.FWD_DI = fwd_sel[2];

`ifdef HCU_STATS_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] annul_cnt_reg;
    logic        stall_event;

    // Startup bubbles are not counted; only hazard-induced ones are.
    assign stall_event = s_int && ((state_reg == ST_RUN) || (state_reg == ST_STALL));

    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            stall_cnt_reg <= 16'd0;
            annul_cnt_reg <= 16'd0;
        end else begin
            if (stall_event && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
            if (clr_int && (annul_cnt_reg != 16'hFFFF)) begin
                annul_cnt_reg <= annul_cnt_reg + 16'd1;
            end
        end
    end

    assign hcu.stall_cnt = stall_cnt_reg;
    assign hcu.annul_cnt = annul_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two instances (1 and 3 load-stall cycles)
// receive identical stimulus; expectations are queued per step and compared at negedge.
module tb_hazard_control_unit;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       imm, store, br, a, br_always, cond;
        logic [4:0] ex_rd, mem_rd, wb_rd;
        logic       ex_en, mem_en, wb_en, ex_ld;
    } stim_t;

    typedef struct {
        string      tag;
        logic       le, s, clr;
        logic [1:0] pa, pb, di, st;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t qa[$];
    exp_t qb[$];

    hazard_control_unit_if if_a ();
    hazard_control_unit_if if_b ();

    hazard_control_unit #(.STARTUP_CYCLES(2), .LOAD_STALL_CYCLES(1)) u_dut_a (
        .Clk (clk),
        .R   (rst),
        .hcu (if_a)
    );

    hazard_control_unit #(.STARTUP_CYCLES(2), .LOAD_STALL_CYCLES(3)) u_dut_b (
        .Clk (clk),
        .R   (rst),
        .hcu (if_b)
    );

    assign if_b.ID_rs1        = if_a.ID_rs1;
    assign if_b.ID_rs2        = if_a.ID_rs2;
    assign if_b.ID_rd         = if_a.ID_rd;
    assign if_b.ID_i          = if_a.ID_i;
    assign if_b.ID_store      = if_a.ID_store;
    assign if_b.ID_B_instr    = if_a.ID_B_instr;
    assign if_b.ID_29_a       = if_a.ID_29_a;
    assign if_b.ID_br_always  = if_a.ID_br_always;
    assign if_b.ID_cond_true  = if_a.ID_cond_true;
    assign if_b.EX_RD         = if_a.EX_RD;
    assign if_b.MEM_RD        = if_a.MEM_RD;
    assign if_b.WB_RD         = if_a.WB_RD;
    assign if_b.EX_RF_enable  = if_a.EX_RF_enable;
    assign if_b.MEM_RF_enable = if_a.MEM_RF_enable;
    assign if_b.WB_RF_enable  = if_a.WB_RF_enable;
    assign if_b.EX_load_instr = if_a.EX_load_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_exp(input string dut, input exp_t e, input logic [2:0] le,
                             input logic s, input logic clr, input logic [1:0] pa,
                             input logic [1:0] pb, input logic [1:0] di, input logic [1:0] st);
        check_val({dut, ".", e.tag, ".LE"},  16'(le),  16'({3{e.le}}));
        check_val({dut, ".", e.tag, ".S"},   16'(s),   16'(e.s));
        check_val({dut, ".", e.tag, ".CLR"}, 16'(clr), 16'(e.clr));
        check_val({dut, ".", e.tag, ".PA"},  16'(pa),  16'(e.pa));
        check_val({dut, ".", e.tag, ".PB"},  16'(pb),  16'(e.pb));
        check_val({dut, ".", e.tag, ".DI"},  16'(di),  16'(e.di));
        check_val({dut, ".", e.tag, ".ST"},  16'(st),  16'(e.st));
    endtask

    function automatic stim_t idle();
        stim_t st;
        st = '{default: '0};
        return st;
    endfunction

    function automatic exp_t mk(input logic le, input logic s, input logic clr,
                                input logic [1:0] pa, input logic [1:0] pb,
                                input logic [1:0] di, input logic [1:0] st);
        exp_t e;
        e.tag = "";
        e.le = le; e.s = s; e.clr = clr;
        e.pa = pa; e.pb = pb; e.di = di; e.st = st;
        return e;
    endfunction

    task automatic drive(input stim_t st);
        rst                = st.rst;
        if_a.ID_rs1        = st.rs1;
        if_a.ID_rs2        = st.rs2;
        if_a.ID_rd         = st.rd;
        if_a.ID_i          = st.imm;
        if_a.ID_store      = st.store;
        if_a.ID_B_instr    = st.br;
        if_a.ID_29_a       = st.a;
        if_a.ID_br_always  = st.br_always;
        if_a.ID_cond_true  = st.cond;
        if_a.EX_RD         = st.ex_rd;
        if_a.MEM_RD        = st.mem_rd;
        if_a.WB_RD         = st.wb_rd;
        if_a.EX_RF_enable  = st.ex_en;
        if_a.MEM_RF_enable = st.mem_en;
        if_a.WB_RF_enable  = st.wb_en;
        if_a.EX_load_instr = st.ex_ld;
    endtask

    // Drive after a rising edge, queue expectations, compare at the following falling edge.
    task automatic step(input string tag, input stim_t st, input exp_t ea,
                        input bit chk_b, input exp_t eb);
        exp_t e;
        @(posedge clk);
        #1;
        drive(st);
        ea.tag = tag;
        qa.push_back(ea);
        if (chk_b) begin
            eb.tag = tag;
            qb.push_back(eb);
        end
        @(negedge clk);
        e = qa.pop_front();
        check_exp("A", e, {if_a.LE_PC, if_a.LE_nPC, if_a.LE_IF_ID}, if_a.S, if_a.IF_ID_clr,
                  if_a.FWD_PA, if_a.FWD_PB, if_a.FWD_DI, if_a.state);
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check_exp("B", e, {if_b.LE_PC, if_b.LE_nPC, if_b.LE_IF_ID}, if_b.S, if_b.IF_ID_clr,
                      if_b.FWD_PA, if_b.FWD_PB, if_b.FWD_DI, if_b.state);
        end
    endtask

    initial begin
        stim_t s_rst, s_rel, s_idle, s_h, s_m, s_t;
        exp_t  e_start, e_run, e_stall_run, e_stall_st, e_fwd_mem, e_b;

        checks = 0;
        errors = 0;

        s_idle = idle();
        s_rst = idle();
        s_rst.rst = 1'b1;
        s_rel = idle();
        drive(s_rst);

        e_start     = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        e_run       = mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
        e_stall_run = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
        e_stall_st  = mk(1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b10);

        // Reset and startup drain: two frozen cycles after release, then RUN.
        step("rst",       s_rst,  e_start, 1, e_start);
        step("startup0",  s_rel,  e_start, 1, e_start);
        step("startup1",  s_idle, e_start, 1, e_start);
        step("run_entry", s_idle, e_run,   1, e_run);

        // ld r5 in EX, add r6,r5,r7 in ID.
        s_h = idle();
        s_h.rs1 = 5'd5; s_h.rs2 = 5'd7; s_h.rd = 5'd6;
        s_h.ex_rd = 5'd5; s_h.ex_en = 1'b1; s_h.ex_ld = 1'b1;
        step("lu_stall", s_h, e_stall_run, 1, e_stall_run);

        // Load now in MEM: A resumes with MEM forwarding; B keeps stalling two more cycles.
        s_m = idle();
        s_m.rs1 = 5'd5; s_m.rs2 = 5'd7; s_m.rd = 5'd6;
        s_m.mem_rd = 5'd5; s_m.mem_en = 1'b1;
        e_fwd_mem = mk(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01);
        e_b       = mk(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10);
        step("lu_release", s_m, e_fwd_mem, 1, e_b);
        step("lu_hold",    s_m, e_fwd_mem, 1, e_b);
        step("lu_resume",  s_m, e_fwd_mem, 1, e_fwd_mem);

        // Load-use detection corner cases.
        s_t = idle();
        s_t.rs1 = 5'd1; s_t.rs2 = 5'd5; s_t.ex_rd = 5'd5; s_t.ex_en = 1'b1; s_t.ex_ld = 1'b1;
        step("lu_rs2", s_t, e_stall_run, 0, e_start);
        s_t.imm = 1'b1;
        step("nolu_imm", s_t, e_run, 0, e_start);
        s_t.rs2 = 5'd2; s_t.rd = 5'd5; s_t.store = 1'b1;
        step("lu_store", s_t, e_stall_run, 0, e_start);
        s_t.store = 1'b0;
        step("nolu_nostore", s_t, e_run, 0, e_start);
        s_t = idle();
        s_t.ex_en = 1'b1; s_t.ex_ld = 1'b1;
        step("nolu_g0", s_t, e_run, 0, e_start);
        s_t.rs1 = 5'd5; s_t.ex_rd = 5'd5; s_t.ex_en = 1'b0;
        step("nolu_noen", s_t, e_run, 0, e_start);

        // Delay-slot annul.
        s_t = idle();
        s_t.br = 1'b1; s_t.a = 1'b1; s_t.cond = 1'b0;
        step("annul_bne_a", s_t, mk(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01), 0, e_start);
        s_t.cond = 1'b1;
        step("annul_taken", s_t, e_run, 0, e_start);
        s_t.br_always = 1'b1;
        step("annul_ba", s_t, mk(1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01), 0, e_start);
        s_t.br_always = 1'b0; s_t.a = 1'b0; s_t.cond = 1'b0;
        step("annul_no_a", s_t, e_run, 0, e_start);
        s_t.a = 1'b1; s_t.rs1 = 5'd5; s_t.ex_rd = 5'd5; s_t.ex_en = 1'b1; s_t.ex_ld = 1'b1;
        step("annul_vs_lu", s_t, e_stall_run, 0, e_start);
        s_t.ex_rd = 5'd0; s_t.ex_en = 1'b0; s_t.ex_ld = 1'b0;
        s_t.mem_rd = 5'd5; s_t.mem_en = 1'b1;
        step("annul_release", s_t, mk(1'b1, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b01), 0, e_start);

        // Forwarding priority and %g0.
        s_t = idle();
        s_t.ex_rd = 5'd9; s_t.mem_rd = 5'd9; s_t.wb_rd = 5'd9;
        s_t.ex_en = 1'b1; s_t.mem_en = 1'b1; s_t.wb_en = 1'b1;
        s_t.rs1 = 5'd9;
        step("fwd_ex", s_t, mk(1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01), 0, e_start);
        s_t.ex_en = 1'b0;
        step("fwd_mem", s_t, mk(1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01), 0, e_start);
        s_t.ex_en = 1'b1; s_t.rs1 = 5'd0;
        s_t.ex_rd = 5'd0; s_t.mem_rd = 5'd0; s_t.wb_rd = 5'd0;
        step("fwd_g0", s_t, e_run, 0, e_start);
        s_t.ex_rd = 5'd9; s_t.mem_rd = 5'd9; s_t.wb_rd = 5'd9;
        s_t.rs1 = 5'd3; s_t.rs2 = 5'd9; s_t.imm = 1'b1;
        step("fwd_pb_imm", s_t, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01), 0, e_start);
        s_t.ex_ld = 1'b1;
        step("fwd_pb_ld", s_t, mk(1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01), 0, e_start);
        s_t = idle();
        s_t.rs1 = 5'd2; s_t.rs2 = 5'd1; s_t.rd = 5'd9;
        s_t.ex_rd = 5'd1; s_t.mem_rd = 5'd2; s_t.wb_rd = 5'd9;
        s_t.ex_en = 1'b1; s_t.mem_en = 1'b1; s_t.wb_en = 1'b1;
        step("fwd_all", s_t, mk(1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 2'b11, 2'b01), 0, e_start);
        s_t.wb_en = 1'b0;
        step("fwd_wb_off", s_t, mk(1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b01), 0, e_start);

        // Both instances back in RUN, then reset lands in the middle of B's stall.
        for (int i = 0; i < 3; i++) begin
            step("settle", s_idle, e_run, 1, e_run);
        end
        step("b_lu",    s_h, e_stall_run, 1, e_stall_run);
        step("b_stall", s_h, e_stall_run, 1, e_stall_st);
        s_t = s_h;
        s_t.rst = 1'b1;
        step("rst_mid_stall", s_t, e_start, 1, e_start);
`ifdef HCU_STATS_EN
        check_val("stats_stall_a", if_a.stall_cnt, 16'd0);
        check_val("stats_annul_a", if_a.annul_cnt, 16'd0);
        check_val("stats_stall_b", if_b.stall_cnt, 16'd0);
        check_val("stats_annul_b", if_b.annul_cnt, 16'd0);
`endif
        step("restart0",  s_rel,  e_start, 1, e_start);
        step("restart1",  s_idle, e_start, 1, e_start);
        step("restart_run", s_idle, e_run, 1, e_run);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
